// File: rtl/reg_wb_arbiter.sv
// Register-page header plus single register-file write port arbiter.
// Loads win the write port; a colliding ALU write waits in a one-entry hold.
module reg_wb_arbiter #(
    parameter int PAGE_W  = 2,
    parameter int FIELD_W = 2,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        set_pa_en,
    input  logic [PAGE_W-1:0]           set_pa_val,
    input  logic                        alu_wr_valid,
    input  logic [FIELD_W-1:0]          alu_wr_field,
    input  logic [DATA_W-1:0]           alu_wr_data,
    input  logic                        ld_wr_valid,
    input  logic [PAGE_W+FIELD_W-1:0]   ld_wr_addr,
    input  logic [DATA_W-1:0]           ld_wr_data,
    input  logic [FIELD_W-1:0]          rd_field,
    output logic [PAGE_W-1:0]           page,
    output logic [PAGE_W+FIELD_W-1:0]   rd_addr,
    output logic                        rd_hazard,
    output logic                        alu_stall,
    output logic                        rf_we,
    output logic [PAGE_W+FIELD_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [CNT_W-1:0]            conflict_cnt
);
    localparam int AW = PAGE_W + FIELD_W;

    typedef enum logic {IDLE, HELD} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [AW-1:0]     alu_addr;
    logic              we_nx, capture, bump;
    logic [AW-1:0]     waddr_nx;
    logic [DATA_W-1:0] wdata_nx;

    // Old page is used here: a same-cycle set-page only takes effect at the edge.
    assign alu_addr  = {page, alu_wr_field};
    assign rd_addr   = {page, rd_field};
    assign alu_stall = (state == HELD);
    assign rd_hazard = (state == HELD) && (hold_addr == rd_addr);

    always_comb begin
        state_nx = state;
        we_nx    = 1'b0;
        waddr_nx = rf_waddr;
        wdata_nx = rf_wdata;
        capture  = 1'b0;
        bump     = 1'b0;
        case (state)
            IDLE: begin
                if (ld_wr_valid) begin
                    we_nx    = 1'b1;
                    waddr_nx = ld_wr_addr;
                    wdata_nx = ld_wr_data;
                    if (alu_wr_valid) begin
                        capture  = 1'b1;
                        bump     = 1'b1;
                        state_nx = HELD;
                    end
                end else if (alu_wr_valid) begin
                    we_nx    = 1'b1;
                    waddr_nx = alu_addr;
                    wdata_nx = alu_wr_data;
                end
            end
            HELD: begin
                if (ld_wr_valid) begin
                    we_nx    = 1'b1;
                    waddr_nx = ld_wr_addr;
                    wdata_nx = ld_wr_data;
                    bump     = alu_wr_valid;
                end else begin
                    // Held write drains; any new ALU request stays stalled this cycle.
                    we_nx    = 1'b1;
                    waddr_nx = hold_addr;
                    wdata_nx = hold_data;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            page         <= '0;
            hold_addr    <= '0;
            hold_data    <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            conflict_cnt <= '0;
        end else begin
            state    <= state_nx;
            rf_we    <= we_nx;
            rf_waddr <= waddr_nx;
            rf_wdata <= wdata_nx;
            if (set_pa_en) page <= set_pa_val;
            if (capture) begin
                hold_addr <= alu_addr;
                hold_data <= alu_wr_data;
            end
            if (bump && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed vector bench for reg_wb_arbiter with hand-computed expectations.
module tb_reg_wb_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       set_pa_en;
    logic [1:0] set_pa_val;
    logic       alu_wr_valid;
    logic [1:0] alu_wr_field;
    logic [7:0] alu_wr_data;
    logic       ld_wr_valid;
    logic [3:0] ld_wr_addr;
    logic [7:0] ld_wr_data;
    logic [1:0] rd_field;
    logic [1:0] page;
    logic [3:0] rd_addr;
    logic       rd_hazard;
    logic       alu_stall;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .set_pa_en(set_pa_en), .set_pa_val(set_pa_val),
        .alu_wr_valid(alu_wr_valid), .alu_wr_field(alu_wr_field), .alu_wr_data(alu_wr_data),
        .ld_wr_valid(ld_wr_valid), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
        .rd_field(rd_field), .page(page), .rd_addr(rd_addr), .rd_hazard(rd_hazard),
        .alu_stall(alu_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        logic       spe;
        logic [1:0] spv;
        logic       av;
        logic [1:0] af;
        logic [7:0] ad;
        logic       lv;
        logic [3:0] la;
        logic [7:0] ldd;
        logic [1:0] rf;
        logic [1:0] e_page;
        logic [3:0] e_rdaddr;
        logic       e_haz;
        logic       e_stall;
        logic       e_we;
        logic [3:0] e_waddr;
        logic [7:0] e_wdata;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tv [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        set_pa_en = 0; set_pa_val = 0; alu_wr_valid = 0; alu_wr_field = 0; alu_wr_data = 0;
        ld_wr_valid = 0; ld_wr_addr = 0; ld_wr_data = 0; rd_field = 0;
    endtask

    initial begin
        //        spe spv av af ad     lv la    ldd    rf  page rda  hz st we wa    wd     cnt
        tv[0]  = '{1, 2, 0, 0, 8'h00, 0, 4'h0, 8'h00, 1,  2,   4'h9, 0, 0, 0, 4'h0, 8'h00, 0};
        tv[1]  = '{1, 1, 0, 0, 8'h00, 0, 4'h0, 8'h00, 1,  1,   4'h5, 0, 0, 0, 4'h0, 8'h00, 0};
        tv[2]  = '{0, 0, 1, 3, 8'h5A, 0, 4'h0, 8'h00, 1,  1,   4'h5, 0, 0, 1, 4'h7, 8'h5A, 0};
        tv[3]  = '{0, 0, 1, 3, 8'h22, 1, 4'h7, 8'h11, 3,  1,   4'h7, 1, 1, 1, 4'h7, 8'h11, 1};
        tv[4]  = '{0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 3,  1,   4'h7, 0, 0, 1, 4'h7, 8'h22, 1};
        tv[5]  = '{0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 3,  1,   4'h7, 0, 0, 0, 4'h7, 8'h22, 1};
        tv[6]  = '{0, 0, 1, 0, 8'h44, 1, 4'h2, 8'h33, 0,  1,   4'h4, 1, 1, 1, 4'h2, 8'h33, 2};
        tv[7]  = '{0, 0, 0, 0, 8'h00, 1, 4'h3, 8'h55, 0,  1,   4'h4, 1, 1, 1, 4'h3, 8'h55, 2};
        tv[8]  = '{0, 0, 0, 0, 8'h00, 1, 4'h8, 8'h66, 0,  1,   4'h4, 1, 1, 1, 4'h8, 8'h66, 2};
        tv[9]  = '{0, 0, 0, 0, 8'h00, 1, 4'h9, 8'h77, 0,  1,   4'h4, 1, 1, 1, 4'h9, 8'h77, 2};
        tv[10] = '{0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0,  1,   4'h4, 0, 0, 1, 4'h4, 8'h44, 2};
        tv[11] = '{0, 0, 1, 1, 8'h99, 1, 4'hA, 8'h01, 1,  1,   4'h5, 1, 1, 1, 4'hA, 8'h01, 3};
        tv[12] = '{0, 0, 1, 2, 8'hAA, 0, 4'h0, 8'h00, 1,  1,   4'h5, 0, 0, 1, 4'h5, 8'h99, 3};
        tv[13] = '{0, 0, 1, 2, 8'hAA, 0, 4'h0, 8'h00, 1,  1,   4'h5, 0, 0, 1, 4'h6, 8'hAA, 3};
        tv[14] = '{1, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 1,  0,   4'h1, 0, 0, 0, 4'h6, 8'hAA, 3};
        tv[15] = '{1, 3, 1, 0, 8'hBB, 0, 4'h0, 8'h00, 1,  3,   4'hD, 0, 0, 1, 4'h0, 8'hBB, 3};
        tv[16] = '{0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 1,  3,   4'hD, 0, 0, 0, 4'h0, 8'hBB, 3};

        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_page", page, 0);
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_stall", alu_stall, 0);
        @(negedge clk) reset = 0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            set_pa_en = tv[i].spe; set_pa_val = tv[i].spv;
            alu_wr_valid = tv[i].av; alu_wr_field = tv[i].af; alu_wr_data = tv[i].ad;
            ld_wr_valid = tv[i].lv; ld_wr_addr = tv[i].la; ld_wr_data = tv[i].ldd;
            rd_field = tv[i].rf;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_page", i), page, tv[i].e_page);
            check($sformatf("v%0d_rd_addr", i), rd_addr, tv[i].e_rdaddr);
            check($sformatf("v%0d_hazard", i), rd_hazard, tv[i].e_haz);
            check($sformatf("v%0d_stall", i), alu_stall, tv[i].e_stall);
            check($sformatf("v%0d_we", i), rf_we, tv[i].e_we);
            if (tv[i].e_we) begin
                check($sformatf("v%0d_waddr", i), rf_waddr, tv[i].e_waddr);
                check($sformatf("v%0d_wdata", i), rf_wdata, tv[i].e_wdata);
            end
            check($sformatf("v%0d_cnt", i), conflict_cnt, tv[i].e_cnt);
        end

        // Reset while HELD: held write must be dropped, counter cleared.
        @(negedge clk);
        idle_inputs();
        alu_wr_valid = 1; alu_wr_field = 2; alu_wr_data = 8'hC3;
        ld_wr_valid = 1; ld_wr_addr = 4'hE; ld_wr_data = 8'h3C;
        @(posedge clk);
        #1;
        check("rh_stall_before", alu_stall, 1);
        check("rh_we_before", rf_we, 1);
        idle_inputs();
        #2 reset = 1;
        #1;
        check("rh_we_async", rf_we, 0);
        check("rh_cnt_async", conflict_cnt, 0);
        check("rh_stall_async", alu_stall, 0);
        @(negedge clk) reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rh_no_write%0d", i), rf_we, 0);
        end

        // Sustained collisions: counter climbs one per cycle then pins at FF.
        @(negedge clk);
        alu_wr_valid = 1; alu_wr_field = 1; alu_wr_data = 8'h10;
        ld_wr_valid = 1; ld_wr_addr = 4'h3; ld_wr_data = 8'h20;
        for (int n = 1; n <= 260; n++) begin
            @(posedge clk);
            #1;
            if (n == 100) check("sat_mid", conflict_cnt, 100);
            if (n == 255) check("sat_reach", conflict_cnt, 8'hFF);
        end
        check("sat_hold", conflict_cnt, 8'hFF);
        check("sat_stall", alu_stall, 1);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("sat_drain_we", rf_we, 1);
        check("sat_drain_addr", rf_waddr, 4'h1);
        check("sat_drain_data", rf_wdata, 8'h10);
        check("sat_after", conflict_cnt, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Owns the register-page header and the single register-file write port.
- Composes 4-bit register addresses as {page, 2-bit instr field}. Arbitrates write-back between the ALU path and the load path.
- Parks a losing ALU write in a one-entry hold register and back-pressures decode until that write drains.
- Sits between decode/execute and the register file.

Parameters:
PAGE_W, 2, width of page header (upper address bits)
FIELD_W, 2, width of register field carried in the instruction
DATA_W, 8, register data width
CNT_W, 8, width of saturating conflict counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
set_pa_en  input  1  set-page instruction strobe
set_pa_val  input  PAGE_W  new page header value
alu_wr_valid  input  1  ALU write-back request
alu_wr_field  input  FIELD_W  ALU destination field (page-relative)
alu_wr_data  input  DATA_W  ALU result
ld_wr_valid  input  1  load write-back request
ld_wr_addr  input  PAGE_W+FIELD_W  absolute load destination (captured at load issue)
ld_wr_data  input  DATA_W  load data
rd_field  input  FIELD_W  source field from decode
page  output  PAGE_W  current page header
rd_addr  output  PAGE_W+FIELD_W  combinational {page, rd_field}
rd_hazard  output  1  hold valid and hold address == rd_addr
alu_stall  output  1  ALU request not accepted this cycle
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  PAGE_W+FIELD_W  register-file write address (registered)
rf_wdata  output  DATA_W  register-file write data (registered)
conflict_cnt  output  CNT_W  count of ALU/load collisions, saturating

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values:
  - page=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - Hold register empty, state IDLE, conflict_cnt=0.
- Reset mid-operation discards any held ALU write; it is never written.

Page register:
- set_pa_en=1 loads set_pa_val at the next edge.
- An ALU request accepted in the same cycle composes its address with the old page.

Address composition:
- ALU address = {page, alu_wr_field}, sampled when the request is accepted.
- Loads use ld_wr_addr unmodified.

Write port:
- Registered, 1-cycle latency from request to rf_we.
- At most one write per cycle.
- Priority: load > held ALU > new ALU.

alu_stall:
- alu_stall = (state==HELD), combinational.
- When stalled, upstream keeps alu_wr_* stable; the request is not consumed.

FSM states IDLE and HELD:
- IDLE, ld & alu: issue load; capture ALU into hold; conflict_cnt++; go to HELD.
- IDLE, ld only: issue load; stay IDLE.
- IDLE, alu only: issue ALU; stay IDLE.
- IDLE, neither: rf_we=0 next cycle.
- HELD, ld: issue load; stay HELD; conflict_cnt++ if alu_wr_valid.
- HELD, no ld: issue held ALU write; go to IDLE. A new ALU request this cycle is still stalled and is accepted the following cycle.

Ordering and hazards:
- Same-address collision: the load is written first and the ALU write later. The ALU write is younger, so its value must end in the register.
- rd_hazard: combinational; compares the hold address with the current rd_addr.
- conflict_cnt: saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Reset, then set_pa_en=1, set_pa_val=2'b10; rd_field=2'b01 -> page=2 next cycle; rd_addr=4'h9.
- IDLE: alu_wr_valid=1, field=3, data=8'h5A, page=1 -> next cycle rf_we=1, rf_waddr=4'h7, rf_wdata=8'h5A; alu_stall=0 throughout.
- Same cycle: ld (addr 4'h7, data 8'h11) and ALU (field 3, data 8'h22), page=1 ->
  - cycle+1: write 4'h7 = 8'h11.
  - cycle+2: write 4'h7 = 8'h22.
  - alu_stall=1 for one cycle; conflict_cnt=1.
  - rd_field=3 during HELD gives rd_hazard=1.
- HELD with 3 back-to-back loads -> three load writes first; held ALU write on the 4th cycle; alu_stall high for 4 cycles.
- Same-cycle set_pa_en (val 3) and ALU field 0 with page=0 -> write addr 4'h0; page=3 after.
- Assert reset while HELD -> rf_we=0 immediately; held write never appears; conflict_cnt=0.
- Force 260 collisions -> conflict_cnt holds at 8'hFF.
